// File: rtl/tnoc_flit_if_fifo_pkg.sv
// Shared NoC configuration and flit types used by the flit interface FIFO.
// Also holds the output FSM state encoding and the flit-width helper.
package tnoc_flit_if_fifo_pkg;

  localparam int TNOC_DATA_WIDTH      = 32;
  localparam int TNOC_FLIT_CTRL_WIDTH = 4;

  typedef struct packed {
    int data_width;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{data_width: TNOC_DATA_WIDTH};

  typedef enum logic [1:0] {
    TNOC_REQUEST  = 2'd0,
    TNOC_RESPONSE = 2'd1,
    TNOC_POSTED   = 2'd2,
    TNOC_CONTROL  = 2'd3
  } tnoc_flit_type;

  typedef struct packed {
    logic                       head;
    logic                       tail;
    tnoc_flit_type              flit_type;
    logic [TNOC_DATA_WIDTH-1:0] data;
  } tnoc_flit;

  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } tnoc_out_state;

  function automatic int tnoc_flit_width(tnoc_config cfg);
    return cfg.data_width + TNOC_FLIT_CTRL_WIDTH;
  endfunction

endpackage

// File: rtl/tnoc_flit_if_fifo_if.sv
// Flit handshake bundle: valid/ready per flit plus a per-packet VC credit.
// master drives flits downstream; slave accepts them and returns credit.
interface tnoc_flit_if_fifo_if;
  import tnoc_flit_if_fifo_pkg::*;

  logic     valid;
  logic     ready;
  logic     vc_available;
  tnoc_flit flit;

  modport master (output valid, output flit, input ready, input vc_available);
  modport slave  (input valid, input flit, output ready, output vc_available);

endinterface

// File: rtl/tnoc_fifo.sv
// Circular flit store with wrap-around pointers valid for any DEPTH >= 2.
// Read data is the entry at the read pointer; storage is never reset.
module tnoc_fifo #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 4,
  localparam int COUNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [COUNT_W-1:0]    count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;

  function automatic logic [PTR_W-1:0] ptr_next(logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_next(wptr);
      if (pop)  rptr <= ptr_next(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == COUNT_W'(DEPTH));

endmodule

// File: rtl/tnoc_flit_if_fifo.sv
// Flit FIFO between two NoC flit interfaces; gates packet starts on the
// downstream VC credit and advertises its own credit from free space.
module tnoc_flit_if_fifo
  import tnoc_flit_if_fifo_pkg::*;
#(
  parameter tnoc_config CONFIG       = TNOC_DEFAULT_CONFIG,
  parameter int         DEPTH        = 4,
  parameter int         VC_THRESHOLD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tnoc_flit_if_fifo_if.slave   flit_in_if,
  tnoc_flit_if_fifo_if.master  flit_out_if
);

  localparam int FLIT_WIDTH = tnoc_flit_width(CONFIG);
  localparam int COUNT_W    = $clog2(DEPTH + 1);

  if (FLIT_WIDTH != $bits(tnoc_flit)) begin : g_width_check
    $error("CONFIG flit width does not match tnoc_flit");
  end

  logic               push;
  logic               pop;
  logic               empty;
  logic               full;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] next_count;
  logic               vc_available_q;
  tnoc_flit           front;
  tnoc_out_state      state_q;
  tnoc_out_state      state_d;

  // Ready looks only at count, so a full FIFO never writes through on a pop.
  assign flit_in_if.ready        = !full;
  assign flit_in_if.vc_available = vc_available_q;
  assign push                    = flit_in_if.valid && !full;
  assign pop                     = flit_out_if.valid && flit_out_if.ready;
  assign flit_out_if.flit        = front;

  tnoc_fifo #(
    .DATA_WIDTH (FLIT_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (flit_in_if.flit),
    .rdata (front),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    next_count = count;
    if (push && !pop) next_count = count + 1'b1;
    if (pop && !push) next_count = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vc_available_q <= 1'b1;
    else        vc_available_q <= (DEPTH - int'(next_count)) >= VC_THRESHOLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A packet may only start with downstream credit; once started it runs to its tail.
  always_comb begin
    state_d           = state_q;
    flit_out_if.valid = 1'b0;
    case (state_q)
      IDLE: begin
        flit_out_if.valid = !empty && flit_out_if.vc_available;
        if (flit_out_if.valid && flit_out_if.ready && front.head && !front.tail)
          state_d = IN_PACKET;
      end
      IN_PACKET: begin
        flit_out_if.valid = !empty;
        if (flit_out_if.valid && flit_out_if.ready && front.tail)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  head_expected_in_idle: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == IDLE && flit_out_if.valid) |-> front.head
  );
`endif

endmodule
